right_shift_ctrl: RTL and testbench
===================================

# right_shift_ctrl

Sequencing controller that sits directly upstream of `right_shift_reg` and drives its `load`, `en`, `data` and `data_h` inputs. It accepts parallel words over a valid/ready handshake, loads each word into the shift register, issues exactly DW shift-enable cycles with a selectable fill bit, and keeps a shadow copy of the register. The shadow copy supplies the serial bit stream and the rotate feedback. `right_shift_reg` keeps its own `sync_rst`; this block never drives it.

## Interface
- `DW`, 4, word width; must match `right_shift_reg`, DW ≥ 2.
- `CW`, `$clog2(DW)`, shift-counter width.

- `clk`  in  1  rising-edge clock, shared with `right_shift_reg`.
- `async_rst_n`  in  1  reset, **asynchronous, active-low**.
- `in_valid`  in  1  word offered.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  DW  word to serialize.
- `in_fill`  in  2  fill mode, captured with the word:
  - 00: zeros.
  - 01: ones.
  - 10: rotate.
  - 11: external.
- `ser_in`  in  1  fill bit used in mode 11.
- `pause`  in  1  freeze shifting while high.
- `abort`  in  1  synchronous cancel of the current word.
- `load`  out  1  to `right_shift_reg.load`.
- `en`  out  1  to `right_shift_reg.en`.
- `data`  out  DW  to `right_shift_reg.data`.
- `data_h`  out  1  to `right_shift_reg.data_h`.
- `ser_out`  out  1  bit leaving the register on this shift; equals `shadow[0]`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last shift of a word.

## Operation
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - `in_ready`=1.
  - On an edge with `in_valid`=1: capture `in_data` into `data` and `shadow`, capture `in_fill` into `fill_r`, then go to LOAD.
- LOAD:
  - `load`=1 for exactly one cycle and `en`=0.
  - Next edge: clear `cnt` to 0 and go to SHIFT.
- SHIFT:
  - `en` = !`pause` (combinational).
  - On each edge with `en`=1: `shadow` <= {`data_h`, `shadow[DW-1:1]`} and `cnt` <= `cnt`+1.
  - On the edge where `cnt`==DW-1 and `en`=1: go to IDLE and set `done`=1 for the following cycle.
- `data_h`, combinational from `fill_r`:
  - 00: 0.
  - 01: 1.
  - 10: `shadow[0]`.
  - 11: `ser_in`.
- `ser_out` = `shadow[0]`; it is meaningful only while `en`=1.
- `shadow` mirrors `right_shift_reg.q` at every cycle from the cycle after LOAD until the next load.
- `data` holds the last accepted word. It changes only on acceptance.
- `load` and `en` are never high in the same cycle.
- `abort`:
  - Sampled high in LOAD or SHIFT: go to IDLE on that edge.
  - `load`/`en` are low from the next cycle.
  - No `done` is issued; `shadow` is left as is.
  - Ignored in IDLE.
  - Takes priority over `in_valid` and `pause`.
- `pause`:
  - In SHIFT: holds `cnt` and `shadow`.
  - No effect in IDLE or LOAD; LOAD always completes.

## Timing
- Reset (`async_rst_n`=0, immediate):
  - State IDLE, `cnt`=0, `fill_r`=00.
  - `data`=0, `shadow`=0.
  - `load`=0, `en`=0, `done`=0, `busy`=0, `in_ready`=1.
  - Reset mid-word discards the word; no `done` is issued.
- Accept at edge k:
  - `load`=1 in cycle k→k+1.
  - `en`=1 in cycles k+1 … k+DW (no pause).
  - `done`=1 and `in_ready`=1 in cycle k+DW+1.
- Throughput: one word per DW+2 cycles. A word offered during the `done` cycle is accepted at that cycle's closing edge (back-to-back).
- Pauses: each pause cycle in SHIFT delays `done` by one cycle.
- `in_valid` while `in_ready`=0 is ignored. The source must hold the word until it is accepted.

## Test plan
- Reset, then DW=4: accept 4'b1011 with fill 00.
  - `load` pulses once.
  - `en` is high 4 cycles with `ser_out` = 1,1,0,1.
  - `right_shift_reg.q` ends at 0000; `done` is high one cycle later.
- Fill 10 with word 4'b1011: `ser_out` = 1,1,0,1 and `q` returns to 1011 after 4 shifts. Fill 01 with 0010: `q` ends at 1111.
- Fill 11 with `ser_in` sequence 1,0,0,1 and word 0000: `q` ends at 1001.
- Pause high for 3 cycles after the second shift of 0110/fill 00:
  - `en` is low for those 3 cycles and `cnt` is frozen.
  - `done` arrives 3 cycles late; `q` ends at 0000.
- Abort during the third shift: `busy` drops next cycle and no `done` pulse occurs. A subsequent word 1100 serializes as 0,0,1,1.
- `async_rst_n` pulsed low mid-SHIFT:
  - Outputs go to reset values immediately.
  - Back-to-back words 0101 and 1010 offered continuously after release are accepted DW+2=6 cycles apart, with `done` between them.

Source files
------------

// File: rtl/right_shift_ctrl.sv
// Sequencing controller for right_shift_reg: accepts a word, loads it, then issues
// exactly DW shift enables with a selectable fill bit while keeping a shadow copy.
module right_shift_ctrl #(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_fill,
  input  logic          ser_in,
  input  logic          pause,
  input  logic          abort,
  output logic          load,
  output logic          en,
  output logic [DW-1:0] data,
  output logic          data_h,
  output logic          ser_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'b00,
    FILL_ONE  = 2'b01,
    FILL_ROT  = 2'b10,
    FILL_EXT  = 2'b11
  } fill_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_e        state_q, state_d;
  fill_e         fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic          done_q, done_d;

  always_comb begin
    data_h = 1'b0;
    unique case (fill_q)
      FILL_ZERO: data_h = 1'b0;
      FILL_ONE:  data_h = 1'b1;
      FILL_ROT:  data_h = shadow_q[0];
      FILL_EXT:  data_h = ser_in;
      default:   data_h = 1'b0;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    load     = (state_q == LOAD);
    en       = (state_q == SHIFT) && !pause;
    data     = data_q;
    ser_out  = shadow_q[0];
    done     = done_q;
  end

  // The abort edge still shifts the shadow when en is high, because the
  // downstream register shifts on that same edge; this keeps the mirror exact.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          shadow_d = in_data;
          fill_d   = fill_e'(in_fill);
          state_d  = LOAD;
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          shadow_d = {data_h, shadow_q[DW-1:1]};
          cnt_d    = cnt_q + 1'b1;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (en && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= IDLE;
      fill_q   <= FILL_ZERO;
      cnt_q    <= '0;
      data_q   <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_right_shift_ctrl.sv
// Bench for right_shift_ctrl: a behavioural right_shift_reg model, a serial-bit
// scoreboard, a table of single-word cases and hand-written reset/back-to-back runs.
module tb_right_shift_ctrl;

  logic       clk = 1'b0;
  logic       async_rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic [1:0] in_fill = '0;
  logic       ser_in = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       load, en, data_h, ser_out, busy, done;
  logic [3:0] data;

  logic [3:0] q_m = '0;
  bit         sb[$];
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    logic [3:0]  word;
    logic [1:0]  fill;
    logic [3:0]  ser_seq;
    logic [3:0]  exp_ser;
    int unsigned pause_len;
    int unsigned abort_at;
    logic [3:0]  exp_q;
  } vec_t;

  right_shift_ctrl #(.DW(4)) dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_fill(in_fill),
    .ser_in(ser_in), .pause(pause), .abort(abort),
    .load(load), .en(en), .data(data), .data_h(data_h),
    .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream right_shift_reg
  always @(posedge clk) begin
    if (load) q_m <= data;
    else if (en) q_m <= {data_h, q_m[3:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (async_rst_n && en) begin
      if (sb.size() == 0) check("unexpected_shift", 32'd1, 32'd0);
      else check("ser_out", ser_out, sb.pop_front());
    end
  end

  task automatic run_word(input vec_t v);
    int unsigned shifts = 0;
    int unsigned pused = 0;
    int unsigned nbits;
    logic [3:0]  seq;
    logic [3:0]  exs;
    bit          aborted = 0;
    seq = v.ser_seq;
    exs = v.exp_ser;
    @(negedge clk);
    in_valid = 1'b1; in_data = v.word; in_fill = v.fill;
    #1;
    check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_data = 4'($urandom);
    #1;
    check("load_pulse", load, 1);
    check("en_in_load", en, 0);
    check("busy_load", busy, 1);
    check("in_ready_load", in_ready, 0);
    check("data_captured", data, v.word);
    nbits = (v.abort_at < 4) ? v.abort_at + 1 : 4;
    for (int unsigned i = 0; i < nbits; i++) sb.push_back(exs[i]);
    for (int unsigned it = 0; it <= 4 + v.pause_len; it++) begin
      @(negedge clk);
      pause  = (v.pause_len > 0) && (shifts == 2) && (pused < v.pause_len);
      if (pause) pused++;
      abort  = (shifts == v.abort_at);
      ser_in = (shifts < 4) ? seq[shifts[1:0]] : 1'b0;
      #1;
      if (abort) begin
        check("en_abort_cycle", en, 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("busy_after_abort", busy, 0);
        check("en_after_abort", en, 0);
        check("load_after_abort", load, 0);
        for (int k = 0; k < 3; k++) begin
          check("no_done_abort", done, 0);
          @(negedge clk);
          #1;
        end
        aborted = 1;
        break;
      end
      check("en_cycle", en, (it < 4 + v.pause_len) && !pause);
      check("load_low", load, 0);
      check("done_timing", done, it == 4 + v.pause_len);
      if (en) shifts++;
    end
    pause = 1'b0;
    abort = 1'b0;
    if (!aborted) begin
      check("shift_count", shifts, 4);
      check("in_ready_done", in_ready, 1);
      check("busy_done", busy, 0);
      check("data_held", data, v.word);
    end
    check("q_final", q_m, v.exp_q);
    check("sb_empty", sb.size(), 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   load_c[2];
    int   done_c[2];
    int   nload = 0;
    int   ndone = 0;
    vecs[0] = '{4'b1011, 2'b00, 4'b0000, 4'b1011, 0, 99, 4'b0000};
    vecs[1] = '{4'b1011, 2'b10, 4'b0000, 4'b1011, 0, 99, 4'b1011};
    vecs[2] = '{4'b0010, 2'b01, 4'b0000, 4'b0010, 0, 99, 4'b1111};
    vecs[3] = '{4'b0000, 2'b11, 4'b1001, 4'b0000, 0, 99, 4'b1001};
    vecs[4] = '{4'b0110, 2'b00, 4'b0000, 4'b0110, 3, 99, 4'b0000};
    vecs[5] = '{4'b0110, 2'b01, 4'b0000, 4'b0110, 0, 2,  4'b1110};
    vecs[6] = '{4'b1100, 2'b00, 4'b0000, 4'b1100, 0, 99, 4'b0000};

    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_load", load, 0);
    check("rst_en", en, 0);
    check("rst_done", done, 0);
    check("rst_data", data, 0);
    check("rst_shadow", ser_out, 0);
    @(negedge clk);
    async_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_word(vecs[i]);

    // Reset pulsed in the middle of a word
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1011; in_fill = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(in_data[i]);
    @(negedge clk);
    #3;
    async_rst_n = 1'b0;
    #1;
    check("midrst_load", load, 0);
    check("midrst_en", en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_data", data, 0);
    check("midrst_shadow", ser_out, 0);
    sb.delete();
    @(negedge clk);
    async_rst_n = 1'b1;

    // Back-to-back words with in_valid held high
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b0101; in_fill = 2'b00;
    for (int i = 0; i < 4; i++) sb.push_back(in_data[i]);
    for (int c = 1; c <= 30 && !(nload == 2 && ndone == 2); c++) begin
      @(negedge clk);
      #1;
      if (load && nload < 2) begin
        load_c[nload] = c;
        nload++;
        if (nload == 1) begin
          check("b2b_data0", data, 4'b0101);
          in_data = 4'b1010;
          for (int i = 0; i < 4; i++) sb.push_back(in_data[i]);
        end else begin
          check("b2b_data1", data, 4'b1010);
          in_valid = 1'b0;
        end
      end
      if (done && ndone < 2) begin
        done_c[ndone] = c;
        ndone++;
        check("b2b_ready_in_done", in_ready, 1);
      end
    end
    in_valid = 1'b0;
    check("b2b_loads", nload, 2);
    check("b2b_dones", ndone, 2);
    if (nload == 2) check("b2b_spacing", load_c[1] - load_c[0], 6);
    if (nload >= 1 && ndone >= 1) check("b2b_done_latency", done_c[0] - load_c[0], 5);
    check("b2b_q_final", q_m, 4'b0000);
    check("b2b_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
